// File: rtl/wb_spi_host_if_if.sv
// wb_spi_host_if_if: Wishbone slave bus plus SPI_MASTER side-band for wb_spi_host_if.
interface wb_spi_host_if_if #(
    parameter int BUF_AW = 8
);
    logic [BUF_AW:0]   wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic              wb_we_i;
    logic              wb_stb_i;
    logic              wb_cyc_i;
    logic              wb_ack_o;
    logic [31:0]       spi_cmd;
    logic [31:0]       spi_rdata;
    logic              spi_ack;
    logic [BUF_AW-1:0] spi_buf_addr;
    logic              spi_buf_we;
    logic              irq_o;
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  spi_rdata, spi_ack, spi_buf_addr, spi_buf_we,
        output wb_dat_o, wb_ack_o, spi_cmd, irq_o
    );
    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output spi_rdata, spi_ack, spi_buf_addr, spi_buf_we,
        input  wb_dat_o, wb_ack_o, spi_cmd, irq_o
    );
endinterface

// File: rtl/wb_spi_host_if.sv
// wb_spi_host_if: Wishbone slave launching SPI_MASTER commands and owning its 2**BUF_AW x 32 receive buffer.
// Define SPI_TIMEOUT_EN to abort a command that sees no spi_ack within TIMEOUT_CYC cycles.
module wb_spi_host_if #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int BUF_AW      = 8
) (
    input logic             clk,
    input logic             rst,
    wb_spi_host_if_if.slave bus
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;
    state_t      r_state;
    logic [31:0] r_mem [2**BUF_AW];
    logic [31:0] r_buf_q, r_reg_q, r_cmd, r_last, r_rdata;
    logic        r_sel_buf, r_ack, r_done, r_err, r_tmo, r_irq_en;
    logic        w_take, w_wr, w_cmd_wr, w_ctrl_wr, w_launch, w_reject, w_finish, w_timeout;
    logic [31:0] w_status, w_reg_rd;

    assign w_take    = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack;
    assign w_wr      = w_take & bus.wb_we_i & ~bus.wb_adr_i[BUF_AW];
    assign w_cmd_wr  = w_wr & (bus.wb_adr_i[1:0] == 2'd0);
    assign w_ctrl_wr = w_wr & (bus.wb_adr_i[1:0] == 2'd3);
    assign w_launch  = w_cmd_wr & (r_state == S_IDLE) & (bus.wb_dat_i != '0);
    assign w_reject  = w_cmd_wr & (r_state == S_BUSY);
    assign w_finish  = (r_state == S_BUSY) & (bus.spi_ack | w_timeout);
    assign w_status  = {28'd0, r_tmo, r_err, r_done, (r_state == S_BUSY)};
    assign w_reg_rd  = (bus.wb_adr_i[1:0] == 2'd0) ? r_last :
                       (bus.wb_adr_i[1:0] == 2'd1) ? w_status :
                       (bus.wb_adr_i[1:0] == 2'd2) ? r_rdata : {31'd0, r_irq_en};

`ifdef SPI_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst || w_launch) r_cnt <= '0;
        else if (r_state == S_BUSY) r_cnt <= r_cnt + 1'b1;
    end
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    // Without the timeout feature a command can never expire.
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    // Read-before-write: a same-cycle SPI fill returns the old word to Wishbone.
    always_ff @(posedge clk) begin
        if (bus.spi_buf_we) r_mem[bus.spi_buf_addr] <= bus.spi_rdata;
        r_buf_q <= r_mem[bus.wb_adr_i[BUF_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_last    <= '0;
            r_rdata   <= '0;
            r_reg_q   <= '0;
            r_sel_buf <= 1'b0;
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tmo     <= 1'b0;
            r_irq_en  <= 1'b0;
        end else begin
            r_ack <= w_take;
            if (w_take && !bus.wb_we_i) begin
                r_sel_buf <= bus.wb_adr_i[BUF_AW];
                r_reg_q   <= w_reg_rd;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= bus.wb_dat_i[0];
                if (bus.wb_dat_i[1]) {r_done, r_err, r_tmo} <= 3'b000;
            end
            if (w_reject) r_err <= 1'b1;
            if (w_launch) begin
                r_cmd   <= bus.wb_dat_i;
                r_last  <= bus.wb_dat_i;
                r_done  <= 1'b0;
                r_state <= S_BUSY;
            end else if (w_finish) begin
                if (bus.spi_ack) r_rdata <= bus.spi_rdata;
                else r_tmo <= 1'b1;
                r_cmd   <= '0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
            end
        end
    end

    assign bus.wb_ack_o = r_ack;
    assign bus.wb_dat_o = r_sel_buf ? r_buf_q : r_reg_q;
    assign bus.spi_cmd  = r_cmd;
    assign bus.irq_o    = r_done & r_irq_en;
endmodule

// File: tb/tb_wb_spi_host_if.sv
// tb_wb_spi_host_if: randomized scoreboard bench for wb_spi_host_if against a transaction-level model.
module tb_wb_spi_host_if;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    string name_q[$];
    bit m_busy, m_done, m_err, m_tmo, m_ien;
    logic [31:0] m_cmd, m_last, m_rdata;
    logic [31:0] m_mem [256];
    logic [7:0] written[$];

    always #5 clk = ~clk;

    wb_spi_host_if_if #(.BUF_AW(8)) bus ();
    wb_spi_host_if #(.TIMEOUT_CYC(16), .BUF_AW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    function automatic void model_reset();
        {m_busy, m_done, m_err, m_tmo, m_ien} = '0;
        m_cmd = '0;
        m_last = '0;
        m_rdata = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [8:0] adr);
        if (adr[8]) return m_mem[adr[7:0]];
        case (adr[1:0])
            2'd0:    return m_last;
            2'd1:    return {28'd0, m_tmo, m_err, m_done, m_busy};
            2'd2:    return m_rdata;
            default: return {31'd0, m_ien};
        endcase
    endfunction

    function automatic void model_write(input logic [8:0] adr, input logic [31:0] d);
        if (adr[8]) return;
        if (adr[1:0] == 2'd0) begin
            if (m_busy) m_err = 1'b1;
            else if (d != 0) begin
                m_cmd = d;
                m_last = d;
                m_busy = 1'b1;
                m_done = 1'b0;
            end
        end else if (adr[1:0] == 2'd3) begin
            m_ien = d[0];
            if (d[1]) {m_done, m_err, m_tmo} = '0;
        end
    endfunction

    function automatic void model_ack(input logic [31:0] d);
        if (m_busy) begin
            m_rdata = d;
            m_busy = 1'b0;
            m_done = 1'b1;
            m_cmd = '0;
        end
    endfunction

    task automatic wb_xfer(input bit we, input logic [8:0] adr, input logic [31:0] d, input string n,
                           input bit with_ack = 1'b0, input logic [31:0] ack_dat = '0);
        if (!we) begin
            exp_q.push_back(model_read(adr));
            name_q.push_back(n);
        end
        bus.wb_adr_i = adr;
        bus.wb_dat_i = d;
        bus.wb_we_i = we;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        if (with_ack) begin
            bus.spi_ack = 1'b1;
            bus.spi_rdata = ack_dat;
        end
        @(negedge clk);
        bus.spi_ack = 1'b0;
        chk({n, "_ack"}, 32'(bus.wb_ack_o), 32'd1);
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        if (we) model_write(adr, d);
        if (with_ack) model_ack(ack_dat);
        @(negedge clk);
        chk({n, "_ack_1cyc"}, 32'(bus.wb_ack_o), 32'd0);
    endtask

    task automatic spi_done(input logic [31:0] d);
        bus.spi_ack = 1'b1;
        bus.spi_rdata = d;
        @(negedge clk);
        bus.spi_ack = 1'b0;
        model_ack(d);
    endtask

    task automatic buf_wr(input logic [7:0] a, input logic [31:0] d);
        bus.spi_buf_we = 1'b1;
        bus.spi_buf_addr = a;
        bus.spi_rdata = d;
        @(negedge clk);
        bus.spi_buf_we = 1'b0;
        m_mem[a] = d;
        written.push_back(a);
    endtask

    task automatic chk_out(input string n);
        chk({n, "_cmd"}, bus.spi_cmd, m_cmd);
        chk({n, "_irq"}, 32'(bus.irq_o), 32'(m_done & m_ien));
    endtask

    // Scoreboard monitor: every read acknowledge pops the oldest expected word.
    initial forever begin
        @(negedge clk);
        if (bus.wb_ack_o && !bus.wb_we_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got %h want none", bus.wb_dat_o);
            end else begin
                chk(name_q.pop_front(), bus.wb_dat_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_we_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.spi_rdata = '0;
        bus.spi_ack = 1'b0;
        bus.spi_buf_addr = '0;
        bus.spi_buf_we = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'd0);
        chk_out("rst");
        rst = 1'b0;
        wb_xfer(1'b0, 9'h001, '0, "rst_status");
        wb_xfer(1'b0, 9'h002, '0, "rst_rdata");
        wb_xfer(1'b0, 9'h003, '0, "rst_ctrl");

        wb_xfer(1'b1, 9'h000, 32'h4154E000, "launch");
        chk_out("launch");
        wb_xfer(1'b1, 9'h000, 32'h12345678, "reject");
        chk_out("reject");
        wb_xfer(1'b0, 9'h001, '0, "status_busy_err");
        wb_xfer(1'b1, 9'h003, 32'h2, "clear");
        wb_xfer(1'b0, 9'h001, '0, "status_busy");
        spi_done(32'hA5A50F0F);
        chk_out("done");
        wb_xfer(1'b0, 9'h001, '0, "status_done");
        wb_xfer(1'b0, 9'h002, '0, "rdata");
        wb_xfer(1'b0, 9'h000, '0, "last_cmd");
        wb_xfer(1'b1, 9'h000, 32'h0, "cmd_zero");
        chk_out("cmd_zero");
        spi_done(32'hDEADBEEF);
        wb_xfer(1'b0, 9'h002, '0, "idle_ack_rdata");
        wb_xfer(1'b0, 9'h001, '0, "idle_ack_status");

        buf_wr(8'h00, 32'h11);
        buf_wr(8'h01, 32'h22);
        buf_wr(8'hFF, 32'hFF);
        buf_wr(8'h05, 32'h55);
        wb_xfer(1'b0, 9'h100, '0, "buf00");
        wb_xfer(1'b0, 9'h101, '0, "buf01");
        wb_xfer(1'b0, 9'h1FF, '0, "bufFF");
        wb_xfer(1'b1, 9'h105, 32'hBAD0BAD0, "buf_wr_ignored");
        wb_xfer(1'b0, 9'h105, '0, "buf05");
        buf_wr(8'h10, 32'h0001_0001);
        bus.spi_buf_we = 1'b1;
        bus.spi_buf_addr = 8'h10;
        bus.spi_rdata = 32'h0002_0002;
        wb_xfer(1'b0, 9'h110, '0, "buf_rw_old");
        bus.spi_buf_we = 1'b0;
        m_mem[8'h10] = 32'h0002_0002;
        wb_xfer(1'b0, 9'h110, '0, "buf_rw_new");

        wb_xfer(1'b1, 9'h003, 32'h3, "irq_en");
        wb_xfer(1'b1, 9'h000, 32'h0C0FFEE0, "irq_launch");
        chk_out("irq_busy");
        spi_done(32'h600D600D);
        chk_out("irq_high");
        wb_xfer(1'b1, 9'h003, 32'h3, "irq_clear");
        chk_out("irq_low");
        wb_xfer(1'b1, 9'h000, 32'h0000_0042, "race_launch");
        wb_xfer(1'b1, 9'h003, 32'h3, "set_wins", 1'b1, 32'h7777_0000);
        chk_out("set_wins");
        wb_xfer(1'b0, 9'h001, '0, "set_wins_status");
        wb_xfer(1'b1, 9'h000, 32'h0000_0043, "rej_ack_launch");
        wb_xfer(1'b1, 9'h000, 32'h0000_0099, "rej_ack", 1'b1, 32'h8888_0000);
        chk_out("rej_ack");
        wb_xfer(1'b0, 9'h001, '0, "rej_ack_status");
        wb_xfer(1'b0, 9'h000, '0, "rej_ack_last");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: buf_wr(8'($urandom), $urandom);
                1: if (written.size() > 0)
                       wb_xfer(1'b0, {1'b1, written[$urandom_range(0, written.size() - 1)]}, '0, "rnd_buf");
                2: wb_xfer(1'b0, {7'd0, 2'($urandom)}, '0, "rnd_reg");
                default: begin
                    wb_xfer(1'b1, 9'h000, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, "rnd_cmd");
                    chk_out("rnd_launch");
                    repeat ($urandom_range(0, 3)) begin
                        case ($urandom_range(0, 2))
                            0: wb_xfer(1'b0, 9'h001, '0, "rnd_busy_status");
                            1: wb_xfer(1'b1, 9'h000, $urandom, "rnd_busy_cmd");
                            default: wb_xfer(1'b1, 9'h003, 32'($urandom_range(0, 3)), "rnd_ctrl");
                        endcase
                    end
                    spi_done($urandom);
                    chk_out("rnd_done");
                    wb_xfer(1'b0, 9'h002, '0, "rnd_rdata");
                end
            endcase
        end

        wb_xfer(1'b1, 9'h003, 32'h2, "to_clear");
        wb_xfer(1'b1, 9'h000, 32'hC0DE0001, "to_launch");
`ifdef SPI_TIMEOUT_EN
        repeat (14) @(negedge clk);
        chk_out("to_before");
        @(negedge clk);
        m_busy = 1'b0;
        m_done = 1'b1;
        m_tmo = 1'b1;
        m_cmd = '0;
        chk_out("to_after");
        chk("to_status_direct", model_read(9'h001), 32'hA);
        wb_xfer(1'b0, 9'h001, '0, "to_status");
        wb_xfer(1'b0, 9'h002, '0, "to_rdata");
        spi_done(32'h1234_4321);
        wb_xfer(1'b0, 9'h002, '0, "to_late_ack");
`else
        repeat (40) @(negedge clk);
        chk_out("no_to");
        wb_xfer(1'b0, 9'h001, '0, "no_to_status");
        spi_done(32'h0BADF00D);
        wb_xfer(1'b0, 9'h002, '0, "no_to_rdata");
`endif

        wb_xfer(1'b1, 9'h000, 32'h5EED0001, "rst_launch");
        bus.spi_ack = 1'b1;
        bus.spi_rdata = 32'hFFFF0000;
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        chk_out("rst_mid");
        chk("rst_mid_dat", bus.wb_dat_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        bus.spi_ack = 1'b0;
        chk_out("rst_ack_ignored");
        wb_xfer(1'b0, 9'h001, '0, "post_rst_status");
        wb_xfer(1'b0, 9'h002, '0, "post_rst_rdata");
        wb_xfer(1'b0, 9'h1FF, '0, "post_rst_buf");

        repeat (2) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
